// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage: one bit per cycle,
// restoring divide and shift-add multiply sharing a 2*WIDTH accumulator.
module ex_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              is_div;
  logic              sign1;
  logic              sign2;
  logic              dz;
  logic [WIDTH-1:0]  opb;
  logic [W2-1:0]     acc;

  logic [WIDTH-1:0]  abs1;
  logic [WIDTH-1:0]  abs2;
  logic [WIDTH:0]    div_diff;
  logic [WIDTH:0]    mul_sum;
  logic [W2-1:0]     acc_step;
  logic [W2-1:0]     acc_fix;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  rem;

  // Operand magnitudes for signed ops; unsigned ops pass straight through.
  always_comb begin
    abs1 = (op_i[0] && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs2 = (op_i[0] && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  end

  // One iteration of the datapath plus the sign fix-up applied on the last one.
  always_comb begin
    div_diff = acc[W2-1:WIDTH-1] - {1'b0, opb};
    mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    if (is_div) begin
      if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_step = {acc[W2-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
    quo = acc_step[WIDTH-1:0];
    rem = acc_step[W2-1:WIDTH];
    if (is_div) begin
      acc_fix = {(sign1 ? -rem : rem), ((sign1 ^ sign2) ? -quo : quo)};
    end else begin
      acc_fix = (sign1 ^ sign2) ? -acc_step : acc_step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_div     <= 1'b0;
      sign1      <= 1'b0;
      sign2      <= 1'b0;
      dz         <= 1'b0;
      opb        <= '0;
      acc        <= '0;
      result_o   <= '0;
      ready_o    <= 1'b0;
      busy_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (annul_i) begin
        // Flush wins over everything; result_o and div_zero_o keep their values.
        state  <= IDLE;
        cnt    <= '0;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              is_div <= ~op_i[1];
              sign1  <= op_i[0] & opdata1_i[WIDTH-1];
              sign2  <= op_i[0] & opdata2_i[WIDTH-1];
              cnt    <= '0;
              busy_o <= 1'b1;
              if (!op_i[1]) begin
                acc <= W2'(abs1);
                opb <= abs2;
              end else begin
                acc <= W2'(abs2);
                opb <= abs1;
              end
              if (!op_i[1] && (opdata2_i == '0)) begin
                dz    <= 1'b1;
                state <= ZERO;
              end else begin
                dz    <= 1'b0;
                state <= RUN;
              end
            end
          end
          ZERO: begin
            acc   <= '0;
            state <= DONE;
          end
          RUN: begin
            if (cnt == CW'(WIDTH - 1)) begin
              acc   <= acc_fix;
              cnt   <= '0;
              state <= DONE;
            end else begin
              acc <= acc_step;
              cnt <= cnt + CW'(1);
            end
          end
          DONE: begin
            result_o   <= acc;
            div_zero_o <= dz;
            ready_o    <= 1'b1;
            busy_o     <= 1'b0;
            state      <= IDLE;
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv (WIDTH=32): directed corner cases plus
// randomized ops checked against an arithmetic reference model.
module tb_ex_muldiv;

  localparam int unsigned WIDTH = 32;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic              annul_i;
  logic [1:0]        op_i;
  logic [WIDTH-1:0]  opdata1_i;
  logic [WIDTH-1:0]  opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic              ready_o;
  logic              busy_o;
  logic              div_zero_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] last_exp = '0;
  logic        last_dz  = 1'b0;

  ex_muldiv #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .op_i       (op_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .div_zero_o (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain SV arithmetic; DIV uses truncating signed division.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int     sa;
    int     sb;
    int     q;
    int     r;
    longint la;
    longint lb;
    logic [63:0] res;
    res = '0;
    case (op)
      2'b00: if (b != 0) res = {a % b, a / b};
      2'b01: begin
        if (b == 0) res = '0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
        else begin
          sa = a; sb = b; q = sa / sb; r = sa % sb;
          res = {r, q};
        end
      end
      2'b10: res = 64'(a) * 64'(b);
      default: begin
        la = longint'($signed(a)); lb = longint'($signed(b));
        res = la * lb;
      end
    endcase
    return res;
  endfunction

  // Issue one op at the next falling edge and check latency, result and flags.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int lat;
    int exp_lat;
    logic exp_dz;
    logic [63:0] exp_res;
    exp_dz  = !op[1] && (b == 0);
    exp_lat = exp_dz ? 2 : WIDTH + 1;
    exp_res = model(op, a, b);
    @(negedge clk);
    start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    check({tag, "_busy"}, 64'(busy_o), 64'(1));
    lat = 0;
    while (!ready_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_dz"}, 64'(div_zero_o), 64'(exp_dz));
    last_exp = exp_res;
    last_dz  = exp_dz;
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(ready_o), 64'(0));
    check({tag, "_hold"}, result_o, exp_res);
  endtask

  initial begin
    int rdy_seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = '0; opdata1_i = '0; opdata2_i = '0;
    #12;
    check("rst_result", result_o, 64'(0));
    check("rst_flags", {61'(0), ready_o, busy_o, div_zero_o}, 64'(0));
    @(posedge clk); #2;
    rst = 1'b1;

    run_op("divu_100_7", 2'b00, 32'd100, 32'd7);
    check("divu_100_7_const", result_o, {32'h2, 32'hE});
    run_op("div_m7_2", 2'b01, 32'hFFFF_FFF9, 32'h2);
    check("div_m7_2_const", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_m1_const", result_o, {32'h0, 32'h8000_0000});
    run_op("divu_5_0", 2'b00, 32'd5, 32'd0);
    run_op("divu_9_3", 2'b00, 32'd9, 32'd3);
    check("divu_9_3_const", result_o, {32'h0, 32'h3});
    run_op("mult_m1_2", 2'b11, 32'hFFFF_FFFF, 32'h2);
    check("mult_m1_2_const", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    run_op("multu_m1_2", 2'b10, 32'hFFFF_FFFF, 32'h2);
    check("multu_m1_2_const", result_o, {32'h1, 32'hFFFF_FFFE});
    run_op("div_zero", 2'b01, 32'hFFFF_FF00, 32'h0);

    // Annul ten cycles into a DIVU: no pulse, prior result and flag retained.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1; annul_i = 1'b0;
    check("annul_busy", 64'(busy_o), 64'(0));
    rdy_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) rdy_seen++;
    end
    check("annul_no_ready", 64'(rdy_seen), 64'(0));
    check("annul_result", result_o, last_exp);
    check("annul_dz", 64'(div_zero_o), 64'(last_dz));

    // start and annul together in IDLE: nothing starts.
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; op_i = 2'b10; opdata1_i = 32'd7; opdata2_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    check("start_annul_busy", 64'(busy_o), 64'(0));
    rdy_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready_o) rdy_seen++;
    end
    check("start_annul_ready", 64'(rdy_seen), 64'(0));

    // Randomized ops with biased divisors.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op("rand", rop, ra, rb);
    end

    // Asynchronous reset between edges in the middle of RUN.
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; opdata1_i = 32'd11; opdata2_i = 32'd13;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_result", result_o, 64'(0));
    check("arst_flags", {61'(0), ready_o, busy_o, div_zero_o}, 64'(0));
    @(posedge clk); #2;
    rst = 1'b1;
    run_op("post_rst_multu", 2'b10, 32'd3, 32'd4);
    check("post_rst_const", result_o, {32'h0, 32'hC});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
